// File: rtl/jtframe_cen_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
// Lock FSM states plus width helpers for the counters.
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT,
    RUN
  } lock_state_e;

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic logic [31:0] lo_mask(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/jtframe_cen_sched_if.sv
// Rate inputs and enable outputs of the scheduler.
// The core side is master, the scheduler is slave.
interface jtframe_cen_sched_if #(
  parameter int W  = 10,
  parameter int WC = 3
);
  logic [W-1:0]  n;
  logic [W-1:0]  m;
  logic          halt;
  logic          rst_out;
  logic [WC-1:0] cen;
  logic [WC-1:0] cenb;
  logic          debt_sat;

  modport master (
    output n, m, halt,
    input  rst_out, cen, cenb, debt_sat
  );

  modport slave (
    input  n, m, halt,
    output rst_out, cen, cenb, debt_sat
  );
endinterface

// File: rtl/jtframe_lock_seq.sv
// PLL lock qualifier: holds the core in reset until
// pll_locked has been stable for LOCK_CNT cycles.
module jtframe_lock_seq
  import jtframe_cen_pkg::*;
#(
  parameter int LOCK_CNT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic run,
  output logic rst_out
);

  localparam int LW = cw(LOCK_CNT);
  localparam logic [LW-1:0] LAST = LW'(LOCK_CNT - 1);

  lock_state_e   state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        lcnt_d = '0;
        if (pll_locked) state_d = COUNT;
      end
      COUNT: begin
        if (!pll_locked) begin
          state_d = WAIT_LOCK;
          lcnt_d  = '0;
        end else if (lcnt_q == LAST) begin
          state_d = RUN;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      RUN: begin
        lcnt_d = '0;
        if (!pll_locked) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        lcnt_d  = '0;
      end
    endcase
  end

  assign rst_out = (state_q != RUN);
  // Gated by the live lock so enables stop on the same edge the FSM leaves RUN
  assign run = (state_q == RUN) & pll_locked;

endmodule

// File: rtl/jtframe_cen_sched.sv
// Fractional clock-enable generator with halt debt and
// binary sub-multiples, released by the lock sequencer.
module jtframe_cen_sched
  import jtframe_cen_pkg::*;
#(
  parameter int W        = 10,
  parameter int WC       = 3,
  parameter int LOCK_CNT = 1024,
  parameter int MAXDEBT  = 3
) (
  input logic clk,
  input logic rst,
  input logic pll_locked,
  jtframe_cen_sched_if.slave bus
);

  localparam int DW = cw(MAXDEBT + 1);
  localparam int CW = (WC > 1) ? WC - 1 : 1;
  localparam logic [DW-1:0] DMAX = DW'(MAXDEBT);

  logic run;
  logic rst_out_w;

  jtframe_lock_seq #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .run       (run),
    .rst_out   (rst_out_w)
  );

  logic [W:0]    acc_q, acc_d;
  logic [DW-1:0] debt_q, debt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WC-1:0] cen_q, cen_d;
  logic [WC-1:0] cenb_q, cenb_d;
  logic          sat_q, sat_d;

  logic [W-1:0] ne;
  logic [W:0]   s;
  logic         tick;
  logic         e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      debt_q <= '0;
      cnt_q  <= '0;
      cen_q  <= '0;
      cenb_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      debt_q <= debt_d;
      cnt_q  <= cnt_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    ne    = (bus.n < bus.m) ? bus.n : bus.m;
    // acc stays below 2^W, so W+1 bits hold the sum
    s     = acc_q + {1'b0, ne};
    tick  = 1'b0;
    acc_d = s;
    if (bus.m == '0) begin
      acc_d = '0;
    end else if (s >= {1'b0, bus.m}) begin
      tick  = 1'b1;
      acc_d = s - {1'b0, bus.m};
    end

    e = !bus.halt & (tick | (debt_q != '0));

    debt_d = debt_q;
    sat_d  = 1'b0;
    if (bus.halt & tick) begin
      if (debt_q == DMAX) sat_d = 1'b1;
      else                debt_d = debt_q + 1'b1;
    end else if (!bus.halt & !tick & (debt_q != '0)) begin
      debt_d = debt_q - 1'b1;
    end

    cnt_d     = e ? cnt_q + 1'b1 : cnt_q;
    cen_d     = '0;
    cenb_d    = '0;
    cen_d[0]  = e;
    for (int k = 1; k < WC; k++) begin
      cen_d[k]  = e & ((32'(cnt_q) & lo_mask(k)) == lo_mask(k));
      cenb_d[k] = e & ((32'(cnt_q) & lo_mask(k)) == (lo_mask(k) >> 1));
    end

    if (!run) begin
      acc_d  = '0;
      debt_d = '0;
      cnt_d  = '0;
      cen_d  = '0;
      cenb_d = '0;
      sat_d  = 1'b0;
    end
  end

  assign bus.rst_out  = rst_out_w;
  assign bus.cen      = cen_q;
  assign bus.cenb     = cenb_q;
  assign bus.debt_sat = sat_q;

endmodule

// File: tb/tb_jtframe_cen_sched.sv
// Bench for jtframe_cen_sched: random and directed stimulus
// against a cycle-level behavioural reference model.
module tb_jtframe_cen_sched;
  import jtframe_cen_pkg::*;

  localparam int W    = 10;
  localparam int WC   = 3;
  localparam int LOCK = 16;
  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll = 1'b0;

  int checks = 0;
  int failures = 0;

  jtframe_cen_sched_if #(.W(W), .WC(WC)) bus();

  jtframe_cen_sched #(
    .W(W), .WC(WC), .LOCK_CNT(LOCK), .MAXDEBT(MAXD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_lr, m_acc, m_debt, m_ecnt;
  logic          x_rst;
  logic [WC-1:0] x_cen, x_cenb;
  logic          x_sat;

  function automatic logic [2*WC+1:0] obs();
    return {bus.rst_out, bus.cen, bus.cenb, bus.debt_sat};
  endfunction

  function automatic logic [2*WC+1:0] expv();
    return {x_rst, x_cen, x_cenb, x_sat};
  endfunction

  task automatic model_reset();
    m_lr = 0; m_acc = 0; m_debt = 0; m_ecnt = 0;
    x_rst = 1'b1; x_cen = '0; x_cenb = '0; x_sat = 1'b0;
  endtask

  task automatic model_step();
    int lr_old, nv, mv, ne, p;
    bit active, tick, e;
    lr_old = m_lr;
    m_lr = pll ? ((m_lr < 1000) ? m_lr + 1 : m_lr) : 0;
    active = pll && (lr_old >= LOCK + 1);
    x_rst = (m_lr < LOCK + 1);
    x_cen = '0; x_cenb = '0; x_sat = 1'b0;
    if (!active) begin
      m_acc = 0; m_debt = 0; m_ecnt = 0;
    end else begin
      nv = int'(bus.n); mv = int'(bus.m);
      ne = (nv < mv) ? nv : mv;
      tick = 0;
      if (mv == 0) m_acc = 0;
      else if (m_acc + ne >= mv) begin tick = 1; m_acc = m_acc + ne - mv; end
      else m_acc = m_acc + ne;
      e = !bus.halt && (tick || m_debt > 0);
      if (bus.halt && tick) begin
        if (m_debt < MAXD) m_debt++;
        else x_sat = 1'b1;
      end else if (!bus.halt && !tick && m_debt > 0) m_debt--;
      x_cen[0] = e;
      for (int k = 1; k < WC; k++) begin
        p = 1 << k;
        x_cen[k]  = e && (m_ecnt % p == p - 1);
        x_cenb[k] = e && (m_ecnt % p == p / 2 - 1);
      end
      if (e) m_ecnt = (m_ecnt + 1) % (1 << (WC - 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    pll = 1'b0;
    bus.n = '0; bus.m = '0; bus.halt = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic go_run(input int nv, input int mv);
    int i;
    do_reset();
    bus.n = W'(nv); bus.m = W'(mv);
    pll = 1'b1;
    i = 0;
    while (bus.rst_out && i < 40) begin step(); i++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (obs() !== {1'b1, {(2*WC+1){1'b0}}}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs(), {1'b1, {(2*WC+1){1'b0}}});
    end
    do_reset();
  endtask

  task automatic test_lock();
    int edges;
    do_reset();
    pll = 1'b1;
    edges = 0;
    while (bus.rst_out && edges < 40) begin
      step(); edges++;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL lock_cyc got=%b exp=%b", obs(), expv());
      end
    end
    checks++;
    if (edges !== LOCK + 1) begin
      failures++;
      $display("FAIL lock_edges got=%0d exp=%0d", edges, LOCK + 1);
    end
    // glitch at counter value 10 restarts the qualification
    do_reset();
    pll = 1'b1;
    repeat (11) step();
    pll = 1'b0;
    step();
    pll = 1'b1;
    edges = 0;
    while (bus.rst_out && edges < 40) begin
      step(); edges++;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL relock_cyc got=%b exp=%b", obs(), expv());
      end
    end
    checks++;
    if (edges !== LOCK + 1) begin
      failures++;
      $display("FAIL relock_edges got=%0d exp=%0d", edges, LOCK + 1);
    end
  endtask

  task automatic test_ratio_1_4();
    int c0, c2, t, last0, lastb1, bad;
    go_run(1, 4);
    c0 = 0; c2 = 0; last0 = -1; lastb1 = -1; bad = 0;
    for (t = 0; t < 64; t++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL r14_cyc t=%0d got=%b exp=%b", t, obs(), expv());
      end
      if (bus.cen[0]) begin
        if (last0 >= 0 && t - last0 != 4) bad++;
        last0 = t; c0++;
      end
      if (bus.cenb[1]) lastb1 = t;
      if (bus.cen[1] && (lastb1 < 0 || t - lastb1 != 4)) bad++;
      if (bus.cen[2]) c2++;
    end
    checks++;
    if (c0 !== 16) begin
      failures++;
      $display("FAIL r14_cen0_count got=%0d exp=16", c0);
    end
    checks++;
    if (c2 !== 4) begin
      failures++;
      $display("FAIL r14_cen2_count got=%0d exp=4", c2);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL r14_spacing got=%0d exp=0", bad);
    end
  endtask

  task automatic test_ratio_misc();
    int c0, last0, close;
    bus.n = 10'd3; bus.m = 10'd8;
    c0 = 0; last0 = -10; close = 0;
    for (int t = 0; t < 800; t++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL r38_cyc t=%0d got=%b exp=%b", t, obs(), expv());
      end
      if (bus.cen[0]) begin
        if (t - last0 < 2) close++;
        last0 = t; c0++;
      end
    end
    checks++;
    if (c0 !== 300) begin
      failures++;
      $display("FAIL r38_count got=%0d exp=300", c0);
    end
    checks++;
    if (close !== 0) begin
      failures++;
      $display("FAIL r38_close got=%0d exp=0", close);
    end
    // n above m clamps to one enable per cycle
    bus.n = 10'd12; bus.m = 10'd8;
    c0 = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (bus.cen[0]) c0++;
    end
    checks++;
    if (c0 !== 20) begin
      failures++;
      $display("FAIL clamp_count got=%0d exp=20", c0);
    end
    bus.n = 10'd5; bus.m = 10'd0;
    c0 = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (bus.cen != '0) c0++;
    end
    checks++;
    if (c0 !== 0) begin
      failures++;
      $display("FAIL m0_count got=%0d exp=0", c0);
    end
  endtask

  task automatic test_halt();
    int hc, sats, runlen;
    go_run(1, 2);
    repeat (6) step();
    bus.halt = 1'b1;
    hc = 0; sats = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL halt_cyc t=%0d got=%b exp=%b", t, obs(), expv());
      end
      if (bus.cen != '0) hc++;
      if (bus.debt_sat) sats++;
    end
    checks++;
    if (hc !== 0 || sats !== 1) begin
      failures++;
      $display("FAIL halt_window got=cen%0d/sat%0d exp=cen0/sat1", hc, sats);
    end
    bus.halt = 1'b0;
    runlen = 0;
    step();
    while (bus.cen[0] && runlen < 20) begin runlen++; step(); end
    checks++;
    if (runlen !== 6) begin
      failures++;
      $display("FAIL payback_run got=%0d exp=6", runlen);
    end
    for (int t = 0; t < 10; t++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL after_pay t=%0d got=%b exp=%b", t, obs(), expv());
      end
    end
  endtask

  task automatic test_lock_loss();
    int edges;
    go_run(1, 2);
    repeat (4) step();
    bus.halt = 1'b1;
    repeat (4) step();
    bus.halt = 1'b0;
    pll = 1'b0;
    step();
    checks++;
    if (bus.rst_out !== 1'b1 || bus.cen !== '0) begin
      failures++;
      $display("FAIL loss_edge got=rst%b/cen%b exp=rst1/cen000", bus.rst_out, bus.cen);
    end
    pll = 1'b1;
    edges = 0;
    while (bus.rst_out && edges < 40) begin step(); edges++; end
    checks++;
    if (edges !== LOCK + 1) begin
      failures++;
      $display("FAIL loss_relock got=%0d exp=%0d", edges, LOCK + 1);
    end
    // acc and debt cleared: first cycle quiet, then 1/2 pattern
    step();
    checks++;
    if (bus.cen[0] !== 1'b0) begin
      failures++;
      $display("FAIL loss_phase0 got=%b exp=0", bus.cen[0]);
    end
    step();
    checks++;
    if (bus.cen[0] !== 1'b1) begin
      failures++;
      $display("FAIL loss_phase1 got=%b exp=1", bus.cen[0]);
    end
  endtask

  task automatic test_async_reset();
    go_run(12, 8);
    repeat (3) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs() !== {1'b1, {(2*WC+1){1'b0}}}) begin
      failures++;
      $display("FAIL async_rst got=%b exp=%b", obs(), {1'b1, {(2*WC+1){1'b0}}});
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int drop;
    go_run(1, 3);
    drop = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t % 37 == 0) begin
        bus.n = W'($urandom_range(0, 40));
        bus.m = W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 3)
                                                : $urandom_range(0, 60));
      end
      if ($urandom_range(0, 9) == 0) bus.halt = ~bus.halt;
      if (drop > 0) begin
        drop--;
        if (drop == 0) pll = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        pll = 1'b0;
        drop = $urandom_range(1, 3);
      end
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL rand t=%0d got=%b exp=%b", t, obs(), expv());
      end
    end
    bus.halt = 1'b0;
    pll = 1'b1;
  endtask

  initial begin
    bus.n = '0; bus.m = '0; bus.halt = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_ratio_1_4();
    test_ratio_misc();
    test_halt();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
